// File: rtl/fpacc_pkg.sv
// Shared definitions for the float32 reduction controller.
package fpacc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_OUT   = 3'd5
    } fpacc_state_t;

    localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
    localparam logic [31:0] FP_POS_ZERO = 32'h00000000;

endpackage

// File: rtl/fpacc_tmo.sv
// Clearable up-counter with a terminal flag; bounds the wait for the adder.
module fpacc_tmo #(
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam int W = $clog2(TMO_CYC + 1);
    localparam logic [W-1:0] TERM = W'(TMO_CYC - 1);

    logic [W-1:0] r_cnt;

    // Count enabled cycles since the last clear, parking at the terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TERM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Terminal on the TMO_CYC-th enabled cycle after a clear.
    assign o_term = (r_cnt == TERM);

endmodule

// File: rtl/fpacc_ctrl.sv
// Reduction controller around a multi-cycle float32 adder: accumulates a
// valid/ready stream into one sum per batch and reports element count and
// adder timeouts. Values pass through bit-exact; no float math here.
module fpacc_ctrl
    import fpacc_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             add_start,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    input  logic             add_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    fpacc_state_t     r_state;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_q;
    logic             r_first;
    logic             r_in_ready;
    logic             r_add_start;
    logic [31:0]      r_add_a;
    logic [31:0]      r_add_b;
    logic             r_out_valid;
    logic [31:0]      r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_err;
    logic             w_tmo_term;
    logic             w_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_accept = in_valid && r_in_ready;

    fpacc_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (r_state == S_START),
        .i_en   (r_state == S_WAIT),
        .o_term (w_tmo_term)
    );

    // Batch FSM with all outputs registered; in_ready is set on entry to accepting states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_acc       <= FP_POS_ZERO;
            r_cnt       <= '0;
            r_last_q    <= 1'b0;
            r_first     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_add_start <= 1'b0;
            r_add_a     <= FP_POS_ZERO;
            r_add_b     <= FP_POS_ZERO;
            r_out_valid <= 1'b0;
            r_out_sum   <= FP_POS_ZERO;
            r_out_count <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc <= in_data;
                        r_cnt <= CNT_W'(1);
                        if (in_last) begin
                            r_state     <= S_OUT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= in_data;
                            r_out_count <= CNT_W'(1);
                        end else begin
                            r_state <= S_ACC;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_add_a     <= r_acc;
                        r_add_b     <= in_data;
                        r_last_q    <= in_last;
                        r_cnt       <= sat_inc(r_cnt);
                        r_add_start <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_add_start <= 1'b0;
                    r_first     <= 1'b1;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    r_first <= 1'b0;
                    if (!r_first && add_done) begin
                        r_acc <= add_sum;
                        if (r_last_q) begin
                            r_state     <= S_OUT;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= add_sum;
                            r_out_count <= r_cnt;
                        end else begin
                            r_state    <= S_ACC;
                            r_in_ready <= 1'b1;
                        end
                    end else if (w_tmo_term) begin
                        r_out_err <= 1'b1;
                        r_acc     <= FP_QNAN;
                        if (r_last_q) begin
                            r_state     <= S_OUT;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= FP_QNAN;
                            r_out_count <= r_cnt;
                        end else begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        r_cnt <= sat_inc(r_cnt);
                        if (in_last) begin
                            r_state     <= S_OUT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= r_acc;
                            r_out_count <= sat_inc(r_cnt);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_err   <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign add_start = r_add_start;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_fpacc_ctrl.sv
// Directed bench for fpacc_ctrl with a behavioural multi-cycle adder stub.
module tb_fpacc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic [15:0] out_count;
    logic        out_err;

    int n_vec = 0;
    int n_bad = 0;
    int n_start = 0;

    // adder stub controls
    int lat = 8;
    bit stale_mode = 1'b0;
    bit never = 1'b0;
    logic [31:0] m_a, m_b;
    bit m_busy, m_drop;
    int m_cnt;

    fpacc_ctrl #(.CNT_W(16), .TMO_CYC(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_done  (add_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // float32 sums used by the vectors, hand-computed
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
            {32'h40400000, 32'h40400000}: return 32'h40C00000; // 3+3=6
            {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
            {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
            default:                      return 32'h12345678;
        endcase
    endfunction

    // Adder stub: latches operands on start, raises done after lat cycles and
    // holds it; in stale mode a previous done lingers one cycle with garbage.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_done <= 1'b0;
            add_sum  <= 32'h0;
            m_busy   <= 1'b0;
            m_drop   <= 1'b0;
            m_cnt    <= 0;
        end else begin
            if (m_drop) begin
                add_done <= 1'b0;
                m_drop   <= 1'b0;
            end
            if (add_start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_a    <= add_a;
                m_b    <= add_b;
                if (stale_mode && add_done) begin
                    add_sum <= 32'hDEADBEEF;
                    m_drop  <= 1'b1;
                end else begin
                    add_done <= 1'b0;
                end
            end else if (m_busy) begin
                if (m_cnt >= lat - 1 && !never) begin
                    add_done <= 1'b1;
                    add_sum  <= fadd(m_a, m_b);
                    m_busy   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) if (add_start) n_start++;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_vec("send_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_vec(tag, out_valid, 1);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_vec("rst_in_ready", in_ready, 0);
        check_vec("rst_add_start", add_start, 0);
        check_vec("rst_out_valid", out_valid, 0);
        check_vec("rst_out_err", out_err, 0);
        check_vec("rst_out_sum", out_sum, 0);
        check_vec("rst_out_count", out_count, 0);
        check_vec("rst_add_a", add_a, 0);
        reset = 1'b1;

        // 1 + 2 + 3 with an 8-cycle adder
        n_start = 0;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        wait_out("b3_valid");
        check_vec("b3_sum", out_sum, 32'h40C00000);
        check_vec("b3_count", out_count, 3);
        check_vec("b3_err", out_err, 0);
        check_vec("b3_starts", n_start, 2);
        check_vec("b3_add_a", add_a, 32'h40400000);
        check_vec("b3_add_b", add_b, 32'h40400000);
        ack();
        check_vec("b3_cleared", out_valid, 0);

        // single element goes straight to OUT without the adder
        n_start = 0;
        send(32'hC1200000, 1'b1);
        check_vec("s1_valid", out_valid, 1);
        check_vec("s1_sum", out_sum, 32'hC1200000);
        check_vec("s1_count", out_count, 1);

        // back-pressure on the result for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_vec("hold_valid", out_valid, 1);
            check_vec("hold_sum", out_sum, 32'hC1200000);
            check_vec("hold_count", out_count, 1);
            check_vec("hold_in_ready", in_ready, 0);
        end
        check_vec("s1_starts", n_start, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h40000000;
        in_last   = 1'b1;
        @(negedge clk);
        check_vec("next_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_vec("next_valid", out_valid, 1);
        check_vec("next_sum", out_sum, 32'h40000000);
        ack();

        // stale done from the previous op must be masked
        stale_mode = 1'b1;
        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        wait_out("stale_valid");
        check_vec("stale_sum", out_sum, 32'h40800000);
        check_vec("stale_count", out_count, 3);
        check_vec("stale_err", out_err, 0);
        ack();
        stale_mode = 1'b0;

        // adder never completes: timeout, drain, QNAN
        never = 1'b1;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b1);
        wait_out("tmo_valid");
        check_vec("tmo_err", out_err, 1);
        check_vec("tmo_sum", out_sum, 32'h7FC00000);
        check_vec("tmo_count", out_count, 4);
        ack();
        check_vec("tmo_err_clr", out_err, 0);
        never = 1'b0;

        // asynchronous reset while waiting on the adder
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        check_vec("rw_start", add_start, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_vec("rw_in_ready", in_ready, 0);
        check_vec("rw_add_start", add_start, 0);
        check_vec("rw_add_a", add_a, 0);
        check_vec("rw_add_b", add_b, 0);
        check_vec("rw_out_valid", out_valid, 0);
        check_vec("rw_out_sum", out_sum, 0);
        check_vec("rw_out_count", out_count, 0);
        check_vec("rw_out_err", out_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_start = 0;
        send(32'h40000000, 1'b0);
        send(32'h40000000, 1'b1);
        wait_out("pr_valid");
        check_vec("pr_sum", out_sum, 32'h40800000);
        check_vec("pr_count", out_count, 2);
        check_vec("pr_starts", n_start, 1);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
